debounce_bank: RTL and testbench
================================

# debounce_bank

Multi-channel switch conditioner: synchronises, debounces and edge-detects `N_CH` independent raw switch inputs and flags long presses. It sits between the board push-buttons and the game/menu logic, replacing per-button single-channel debouncers with one parametrised bank. Each channel delivers a clean level, one-cycle press/release strobes and a one-shot hold strobe.

## Interface
- `N_CH`, 4: number of independent switch channels (≥1).
- `DEBOUNCE_LIMIT`, 250000: consecutive mismatching cycles before the level flips (10 ms at 25 MHz). Must be ≥2.
- `HOLD_LIMIT`, 12500000: cycles the debounced level must stay high before `o_Hold` fires (0.5 s at 25 MHz). Must be ≥2.
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).

- `i_Clk`  in  1  system clock.
- `i_Rst`  in  1  reset, asynchronous, active-high.
- `i_Switch`  in  N_CH  raw switch levels, asynchronous, active-high.
- `o_Switch`  out  N_CH  debounced level per channel.
- `o_Press`  out  N_CH  one-cycle strobe on debounced 0→1.
- `o_Release`  out  N_CH  one-cycle strobe on debounced 1→0.
- `o_Hold`  out  N_CH  one-cycle strobe once per press after HOLD_LIMIT cycles high.

## Operation
- All channels are identical and fully independent; bit k of every port belongs to channel k.
- Synchroniser: `i_Switch[k]` passes through SYNC_STAGES flops; the last stage `sync` is the only value the debouncer sees.
- Debounce counter `cnt` (width `$clog2(DEBOUNCE_LIMIT)`):
  - `sync == o_Switch`: `cnt <= 0`.
  - `sync != o_Switch` and `cnt < DEBOUNCE_LIMIT-1`: `cnt <= cnt+1`.
  - `sync != o_Switch` and `cnt == DEBOUNCE_LIMIT-1`: `o_Switch <= sync`, `cnt <= 0`.
  - Any single agreeing sample restarts the count; no partial credit.
- Edge strobes: `o_Press`/`o_Release` are registered and high exactly in the cycle `o_Switch` first shows its new value; otherwise 0.
- Hold counter `hcnt` (width `$clog2(HOLD_LIMIT)`):
  - `o_Switch == 0`: `hcnt <= 0`, hold-done flag cleared.
  - `o_Switch == 1`, not done: `hcnt` increments; on the cycle `hcnt == HOLD_LIMIT-1`, `o_Hold` pulses for one cycle, done flag set, `hcnt` frozen.
  - Done: no further `o_Hold` until a release clears the flag.
  - `hcnt` starts counting in the cycle after `o_Press`.
- Per-channel FSM (implicit in `o_Switch` + done flag): IDLE (low) → PRESSED (high, counting) → HELD (high, hold fired) → IDLE on release; PRESSED → IDLE on release before HOLD_LIMIT, with no `o_Hold`.

## Timing
- Reset (async assert, release synchronous to `i_Clk` by the system reset sync): every synchroniser flop, `cnt`, `hcnt`, done flag and all outputs = 0.
- Reset mid-count or mid-hold: state discarded immediately; a switch still held at reset release produces a fresh `o_Press` after SYNC_STAGES + DEBOUNCE_LIMIT cycles.
- Latency from a clean input step (set up before edge 0) to `o_Switch` change: SYNC_STAGES + DEBOUNCE_LIMIT cycles. The strobe appears in the same cycle.
- `o_Hold` fires HOLD_LIMIT cycles after the `o_Press` cycle.
- `o_Press` and `o_Release` never coincide on one channel. Simultaneous events on different channels are independent and may share cycles.
- Glitch shorter than DEBOUNCE_LIMIT cycles (after sync): no output change, no strobe.
- Counters never wrap: `cnt` max DEBOUNCE_LIMIT-1, `hcnt` max HOLD_LIMIT-1.

## Structure
- Default timing constants (`DEBOUNCE_LIMIT`, `HOLD_LIMIT` for 25 MHz) live in the shared project constants include alongside the other clock-derived limits; the bank takes them as parameter defaults.
- Natural sub-module: `debounce_channel` (sync + debounce + edge + hold for one bit), instantiated N_CH times in a generate loop. The top level contains only wiring.

## Test plan
Bench configuration: N_CH=2, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10, SYNC_STAGES=2.
- Reset with `i_Switch=2'b11`, release → all outputs 0; `o_Switch[1:0]=11` and `o_Press=11` exactly 6 cycles later.
- Ch0 clean step 0→1 → `o_Switch[0]` rises and `o_Press[0]` is high for 1 cycle, 6 cycles after the step; ch1 unaffected.
- Ch0 high for 3 cycles, low 1, high again → no change until 4 consecutive high samples; exactly one `o_Press[0]`.
- Ch1 held high → `o_Hold[1]` pulses once 10 cycles after `o_Press[1]`, then stays 0 for 50 further cycles. Release → `o_Release[1]` fires, with no hold strobe.
- Ch0 press released 5 cycles after `o_Press` → `o_Release[0]` fires and `o_Hold[0]` never fires. Re-press → hold timing restarts from 0.
- Assert `i_Rst` mid-hold on ch1 (hcnt=7) → outputs 0 immediately; after release, a fresh press, then `o_Hold` after a full 10 cycles.

Source files
------------

// File: rtl/debounce_bank_pkg.sv
// Shared constants and per-channel state encoding for the switch debounce bank.
// The default limits assume a 25 MHz system clock.
package debounce_bank_pkg;

    localparam int DEFAULT_DEBOUNCE_LIMIT = 250_000;    // 10 ms
    localparam int DEFAULT_HOLD_LIMIT     = 12_500_000; // 0.5 s
    localparam int DEFAULT_SYNC_STAGES    = 2;

    // Bit 0 is the debounced level, so o_Switch comes straight off a flop.
    typedef enum logic [1:0] {
        CH_IDLE    = 2'b00,
        CH_PRESSED = 2'b01,
        CH_HELD    = 2'b11
    } ch_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: synchroniser, debounce counter, press/release strobes
// and a one-shot long-press strobe.
module debounce_channel
    import debounce_bank_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Hold
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT);
    localparam int HW = $clog2(HOLD_LIMIT);
    localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_LIMIT - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   sync;
    logic                   level;

    ch_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          hold_q, hold_d;

    // Synchroniser stages
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], i_Switch};
        end
    end

    assign sync  = sync_p[SYNC_STAGES-1];
    assign level = state_q[0];

    // Debounce / hold state
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= CH_IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        hold_d  = 1'b0;

        case (state_q)
            CH_IDLE: hcnt_d = '0;
            CH_PRESSED: begin
                if (hcnt_q == HOLD_MAX) begin
                    hold_d  = 1'b1;
                    state_d = CH_HELD;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: ; // HELD: counter frozen until release
        endcase

        // A release on the same cycle as the hold threshold wins the state.
        if (sync == level) begin
            cnt_d = '0;
        end else if (cnt_q != DB_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
            if (sync) begin
                state_d = CH_PRESSED;
                press_d = 1'b1;
            end else begin
                state_d = CH_IDLE;
                rel_d   = 1'b1;
                hcnt_d  = '0;
            end
        end
    end

    assign o_Switch  = level;
    assign o_Press   = press_q;
    assign o_Release = rel_q;
    assign o_Hold    = hold_q;

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent switch conditioners; wiring only.
module debounce_bank
    import debounce_bank_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int HOLD_LIMIT     = DEFAULT_HOLD_LIMIT,
    parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES
) (
    input  logic            i_Clk,
    input  logic            i_Rst,
    input  logic [N_CH-1:0] i_Switch,
    output logic [N_CH-1:0] o_Switch,
    output logic [N_CH-1:0] o_Press,
    output logic [N_CH-1:0] o_Release,
    output logic [N_CH-1:0] o_Hold
);

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
            .HOLD_LIMIT    (HOLD_LIMIT),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_ch (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Switch (i_Switch[k]),
            .o_Switch (o_Switch[k]),
            .o_Press  (o_Press[k]),
            .o_Release(o_Release[k]),
            .o_Hold   (o_Hold[k])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Event scoreboard bench for debounce_bank: expected strobes are queued with
// their cycle when stimulus is driven and matched as the DUT emits them.
module tb_debounce_bank;

    localparam int N_CH = 2;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + DB;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_HOLD  = 2;

    logic            i_Clk = 1'b0;
    logic            i_Rst = 1'b1;
    logic [N_CH-1:0] i_Switch = '0;
    logic [N_CH-1:0] o_Switch, o_Press, o_Release, o_Hold;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;
    int exp_q[$];

    debounce_bank #(
        .N_CH          (N_CH),
        .DEBOUNCE_LIMIT(DB),
        .HOLD_LIMIT    (HOLD),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Switch (i_Switch),
        .o_Switch (o_Switch),
        .o_Press  (o_Press),
        .o_Release(o_Release),
        .o_Hold   (o_Hold)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ev_key(input int c, input int ch, input int kind);
        return c * 16 + ch * 4 + kind;
    endfunction

    // Sorted insert keeps the queue in emission order.
    task automatic push_exp(input int c, input int ch, input int kind);
        int key;
        int idx;
        key = ev_key(c, ch, kind);
        idx = exp_q.size();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i] > key) begin
                idx = i;
                break;
            end
        end
        exp_q.insert(idx, key);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        chk("drain", exp_q.size(), 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge i_Clk) begin
        while (exp_q.size() != 0 && (exp_q[0] / 16) < cyc) begin
            chk("missed_event", exp_q[0], 32'hFFFF_FFFF);
            void'(exp_q.pop_front());
        end
        for (int ch = 0; ch < N_CH; ch++) begin
            logic [2:0] s;
            s = {o_Hold[ch], o_Release[ch], o_Press[ch]};
            for (int kind = 0; kind < 3; kind++) begin
                if (s[kind]) begin
                    if (exp_q.size() == 0)
                        chk("unexpected_event", ev_key(cyc, ch, kind), 32'hFFFF_FFFF);
                    else
                        chk("event", ev_key(cyc, ch, kind), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int c;
        int p;

        // Reset with both switches already closed
        i_Switch = 2'b11;
        i_Rst    = 1'b1;
        tick(3);
        chk("reset_outputs", {o_Switch, o_Press, o_Release, o_Hold}, 0);
        i_Rst = 1'b0;
        c = cyc;
        push_exp(c + LAT, 0, K_PRESS);
        push_exp(c + LAT, 1, K_PRESS);
        chk("post_reset_level", o_Switch, 2'b00);
        tick(LAT - 1);
        chk("level_before_lat", o_Switch, 2'b00);
        tick(1);
        chk("level_at_lat", o_Switch, 2'b11);
        i_Switch = 2'b00;
        c = cyc;
        push_exp(c + LAT, 0, K_REL);
        push_exp(c + LAT, 1, K_REL);
        drain(20);
        chk("both_released", o_Switch, 2'b00);

        // Ch0 clean step, ch1 untouched; release before hold threshold
        i_Switch[0] = 1'b1;
        c = cyc;
        push_exp(c + LAT, 0, K_PRESS);
        tick(LAT);
        chk("ch0_step_level", o_Switch, 2'b01);
        i_Switch[0] = 1'b0;
        push_exp(cyc + LAT, 0, K_REL);
        drain(20);
        tick(HOLD + 10);
        chk("ch0_short_no_hold", o_Switch, 2'b00);

        // Ch0 glitchy re-press: 3 high, 1 low, then steady high
        i_Switch[0] = 1'b1;
        tick(3);
        i_Switch[0] = 1'b0;
        tick(1);
        i_Switch[0] = 1'b1;
        c = cyc;
        push_exp(c + LAT, 0, K_PRESS);
        push_exp(c + LAT + HOLD, 0, K_HOLD);
        tick(LAT - 1);
        chk("glitch_no_change", o_Switch, 2'b00);
        drain(40);
        tick(20);
        chk("ch0_held_level", o_Switch, 2'b01);
        i_Switch[0] = 1'b0;
        push_exp(cyc + LAT, 0, K_REL);
        drain(20);

        // Ch1 long hold: one hold strobe, then silence for 50 cycles
        i_Switch[1] = 1'b1;
        c = cyc;
        push_exp(c + LAT, 1, K_PRESS);
        push_exp(c + LAT + HOLD, 1, K_HOLD);
        drain(40);
        tick(50);
        chk("ch1_held_level", o_Switch, 2'b10);
        i_Switch[1] = 1'b0;
        push_exp(cyc + LAT, 1, K_REL);
        drain(20);

        // Reset in the middle of a ch1 hold count
        i_Switch[1] = 1'b1;
        c = cyc;
        p = c + LAT;
        push_exp(p, 1, K_PRESS);
        drain(20);
        tick(p + 7 - cyc);
        chk("mid_hold_level", o_Switch, 2'b10);
        i_Rst = 1'b1;
        #1;
        chk("async_reset_outputs", {o_Switch, o_Press, o_Release, o_Hold}, 0);
        tick(2);
        i_Rst = 1'b0;
        c = cyc;
        push_exp(c + LAT, 1, K_PRESS);
        push_exp(c + LAT + HOLD, 1, K_HOLD);
        drain(40);
        i_Switch[1] = 1'b0;
        push_exp(cyc + LAT, 1, K_REL);
        drain(20);
        tick(5);
        chk("final_level", o_Switch, 2'b00);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
